geo_frame_seq: RTL

GEO_FRAME_SEQ -- requirements
Module: geo_frame_seq

---
 rtl/geo_frame_seq.sv | 135 +++++++++++++
 1 files changed

// File: rtl/geo_frame_seq.sv
// Frame sequencer for the geofence core: fetches a target point plus six polygon
// vertices per frame, waits for the core verdict, and logs one result bit per frame.
module geo_frame_seq #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [7:0]  num_frames,
    output logic        mem_rd,
    output logic [10:0] mem_addr,
    input  logic [9:0]  mem_x,
    input  logic [9:0]  mem_y,
    output logic        pt_vld,
    output logic [9:0]  core_x,
    output logic [9:0]  core_y,
    input  logic        core_valid,
    input  logic        core_inside,
    output logic        result_we,
    output logic [7:0]  result_addr,
    output logic        result_bit,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [7:0]  inside_cnt
);

    typedef enum logic [1:0] {IDLE, FETCH, WAIT, DONE} state_t;

    localparam logic [7:0] TIMER_LAST = 8'(TIMEOUT - 1);
    localparam logic [2:0] PT_LAST    = 3'd6;

    state_t      state;
    logic [7:0]  frames;
    logic [7:0]  frame_idx;
    logic [7:0]  timer;
    logic [10:0] base;
    logic [10:0] next_base;
    logic [2:0]  pt_idx;
    logic        last_frame;

    // Each frame occupies seven consecutive words, so stepping the base is a plain add.
    assign next_base  = base + 11'd7;
    assign last_frame = (frame_idx == frames - 8'd1);

    assign core_x      = mem_x;
    assign core_y      = mem_y;
    assign result_we   = (state == WAIT) && core_valid;
    assign result_addr = frame_idx;
    assign result_bit  = core_inside;

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            pt_vld     <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            inside_cnt <= '0;
            frames     <= '0;
            frame_idx  <= '0;
            timer      <= '0;
            base       <= '0;
            pt_idx     <= '0;
        end else begin
            // Read data lands one cycle after the strobe, so the point qualifier trails it.
            pt_vld <= mem_rd;
            case (state)
                IDLE: begin
                    if (start) begin
                        inside_cnt <= '0;
                        err        <= 1'b0;
                        if (num_frames != 8'd0) begin
                            frames    <= num_frames;
                            frame_idx <= '0;
                            base      <= '0;
                            pt_idx    <= '0;
                            mem_addr  <= '0;
                            mem_rd    <= 1'b1;
                            busy      <= 1'b1;
                            state     <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: begin
                    if (pt_idx == PT_LAST) begin
                        mem_rd <= 1'b0;
                        timer  <= '0;
                        state  <= WAIT;
                    end else begin
                        pt_idx   <= pt_idx + 3'd1;
                        mem_addr <= mem_addr + 11'd1;
                    end
                end
                WAIT: begin
                    // A verdict on the last timer cycle still wins over the abort.
                    if (core_valid) begin
                        if (core_inside)
                            inside_cnt <= inside_cnt + 8'd1;
                        if (last_frame) begin
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            frame_idx <= frame_idx + 8'd1;
                            base      <= next_base;
                            mem_addr  <= next_base;
                            pt_idx    <= '0;
                            mem_rd    <= 1'b1;
                            state     <= FETCH;
                        end
                    end else if (timer == TIMER_LAST) begin
                        err   <= 1'b1;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        state <= DONE;
                    end else begin
                        timer <= timer + 8'd1;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
